// File: rtl/flow_cond_loader_if.sv
// rtl/flow_cond_loader_if.sv - AXI4-Lite bus bundle between the condition loader and its register slave
interface flow_cond_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/flow_cond_loader.sv
// rtl/flow_cond_loader.sv - loads one 96-bit flow condition as four AXI4-Lite words; FLOW_COND_LOADER_VERIFY_EN adds readback compare
module flow_cond_loader #(
  parameter int FLOW_NUM       = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [3:0]         cmd_idx_i,
  input  logic [95:0]        cmd_cond_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2:0]         err_code_o,
  flow_cond_loader_if.master m_axi
);

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_IDX     = 3'b001;
  localparam logic [2:0] ERR_RESP    = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_DATA    = 3'b100;

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WR,
    WAIT_B,
    NEXT,
    RD_A,
    RD_R,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [95:0]           cond_q, cond_d;
  logic [1:0]            word_q, word_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            err_code_q, err_code_d;
  logic                  wd_expired;

`ifdef FLOW_COND_LOADER_VERIFY_EN
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
`endif

  // Byte address of word k of slot idx: each slot owns four consecutive 32-bit registers.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [3:0] idx, input logic [1:0] k);
    logic [7:0] byte_addr;
    byte_addr = {idx, k, 2'b00};
    return ADDR_WIDTH'(byte_addr);
  endfunction

  // Register image of word k; ports are zero-extended into their own words.
  function automatic logic [31:0] word_data(input logic [95:0] cond, input logic [1:0] k);
    logic [31:0] d;
    case (k)
      2'd0:    d = cond[95:64];
      2'd1:    d = {16'h0000, cond[63:48]};
      2'd2:    d = cond[47:16];
      default: d = {16'h0000, cond[15:0]};
    endcase
    return d;
  endfunction

  assign wd_expired = (wd_q == WD_LAST);

  // Next-state logic: command sequencing, AXI valid management, error capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cond_d     = cond_q;
    word_d     = word_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
`ifdef FLOW_COND_LOADER_VERIFY_EN
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          idx_d      = cmd_idx_i;
          cond_d     = cmd_cond_i;
          word_d     = 2'd0;
          err_code_d = ERR_NONE;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        if (32'(idx_q) >= 32'(FLOW_NUM - 1)) begin
          err_code_d = ERR_IDX;
          state_d    = FINISH;
        end else begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = word_addr(idx_q, 2'd0);
          wdata_d   = word_data(cond_q, 2'd0);
          state_d   = WR;
        end
      end

      WR: begin
        // Address and data channels retire independently; move on once both have.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WAIT_B;
        end else if (wd_expired) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b0;
          err_code_d = ERR_TIMEOUT;
          state_d    = FINISH;
        end
      end

      WAIT_B: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            err_code_d = ERR_RESP;
            state_d    = FINISH;
          end else begin
            state_d = NEXT;
          end
        end else if (wd_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = FINISH;
        end
      end

      NEXT: begin
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) begin
`ifdef FLOW_COND_LOADER_VERIFY_EN
          arvalid_d = 1'b1;
          araddr_d  = word_addr(idx_q, 2'd0);
          state_d   = RD_A;
`else
          state_d   = FINISH;
`endif
        end else begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = word_addr(idx_q, word_q + 2'd1);
          wdata_d   = word_data(cond_q, word_q + 2'd1);
          state_d   = WR;
        end
      end

`ifdef FLOW_COND_LOADER_VERIFY_EN
      RD_A: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end else if (wd_expired) begin
          arvalid_d  = 1'b0;
          err_code_d = ERR_TIMEOUT;
          state_d    = FINISH;
        end
      end

      RD_R: begin
        if (m_axi.rvalid) begin
          if (m_axi.rresp != 2'b00) begin
            err_code_d = ERR_RESP;
            state_d    = FINISH;
          end else if (m_axi.rdata != word_data(cond_q, word_q)) begin
            err_code_d = ERR_DATA;
            state_d    = FINISH;
          end else if (word_q == 2'd3) begin
            word_d  = 2'd0;
            state_d = FINISH;
          end else begin
            word_d    = word_q + 2'd1;
            arvalid_d = 1'b1;
            araddr_d  = word_addr(idx_q, word_q + 2'd1);
            state_d   = RD_A;
          end
        end else if (wd_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = FINISH;
        end
      end
`endif

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog restarts on every state change and saturates otherwise.
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_expired) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cond_q     <= '0;
      word_q     <= '0;
      wd_q       <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cond_q     <= cond_d;
      word_q     <= word_d;
      wd_q       <= wd_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef FLOW_COND_LOADER_VERIFY_EN
  // Readback address channel registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
    end
  end

  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.rready  = (state_q == RD_R);
`else
  logic unused_rd;
  assign unused_rd     = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid};
  assign m_axi.arvalid = 1'b0;
  assign m_axi.araddr  = '0;
  assign m_axi.rready  = 1'b0;
`endif

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.bready  = (state_q == WAIT_B);
  assign m_axi.arprot  = 3'b000;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FINISH) && (err_code_q == ERR_NONE);
  assign err_o       = (state_q == FINISH) && (err_code_q != ERR_NONE);
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_flow_cond_loader.sv
// tb/tb_flow_cond_loader.sv - directed table-driven bench for flow_cond_loader
module tb_flow_cond_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_idx = '0;
  logic [95:0] cmd_cond = '0;
  logic        busy, done, err;
  logic [2:0]  err_code;

  flow_cond_loader_if #(.ADDR_WIDTH(8)) axi_if ();

  flow_cond_loader #(.FLOW_NUM(16), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_idx_i(cmd_idx), .cmd_cond_i(cmd_cond),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
    .m_axi(axi_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // slave configuration (written by the test)
  int aw_delay = 0, w_delay = 0, bad_word = -1, r_bad_word = -1;
  bit b_hold = 0;

  // slave state (written only by the slave process)
  logic [31:0] mem [64];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int log_n = 0, hs_cnt = 0, w_first_cnt = 0, bready_cnt = 0;
  int aw_wait = 0, w_wait = 0;
  bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [7:0] got_addr = '0, r_addr = '0;
  logic [31:0] got_data = '0;
  logic [1:0] b_resp_q = '0;
  logic awv_s = 0, wv_s = 0, br_s = 0, arv_s = 0, rr_s = 0;
  logic [7:0] awa_s = '0, ara_s = '0;
  logic [31:0] wd_s = '0;

  initial begin
    axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 0;
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 0; axi_if.rresp = 0;
  end

  // AXI4-Lite slave: resolves last posedge's handshakes, then drives for the next one
  always @(negedge clk) begin
    if (rstn) begin
      axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 0;
      axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 0; axi_if.rresp = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_wait = 0; w_wait = 0;
      awv_s = 0; wv_s = 0; br_s = 0; arv_s = 0; rr_s = 0;
    end else begin
      if (axi_if.bvalid && br_s) begin axi_if.bvalid = 0; b_pend = 0; end
      if (awv_s && axi_if.awready) begin aw_got = 1; got_addr = awa_s; aw_wait = 0; hs_cnt++; end
      if (wv_s && axi_if.wready) begin w_got = 1; got_data = wd_s; w_wait = 0; hs_cnt++; end
      if (aw_got && w_got) begin
        log_addr[log_n] = {24'h0, got_addr};
        log_data[log_n] = got_data;
        log_n++;
        mem[got_addr[7:2]] = got_data;
        b_pend = 1;
        b_resp_q = (int'(got_addr[3:2]) == bad_word) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (axi_if.rvalid && rr_s) begin axi_if.rvalid = 0; r_pend = 0; end
      if (arv_s && axi_if.arready) begin r_pend = 1; r_addr = ara_s; end

      axi_if.awready = axi_if.awvalid && !aw_got && (aw_wait >= aw_delay);
      if (axi_if.awvalid && !aw_got) aw_wait++;
      axi_if.wready = axi_if.wvalid && !w_got && (w_wait >= w_delay);
      if (axi_if.wvalid && !w_got) w_wait++;
      axi_if.bvalid = b_pend && !b_hold;
      axi_if.bresp  = b_pend ? b_resp_q : 2'b00;
      axi_if.arready = axi_if.arvalid && !r_pend;
      axi_if.rvalid  = r_pend;
      axi_if.rresp   = 2'b00;
      axi_if.rdata   = mem[r_addr[7:2]] ^ ((int'(r_addr[3:2]) == r_bad_word) ? 32'h0000_0100 : 32'h0);

      if (axi_if.awvalid && !axi_if.wvalid) w_first_cnt++;
      if (axi_if.bready) bready_cnt++;
      awv_s = axi_if.awvalid; awa_s = axi_if.awaddr; wv_s = axi_if.wvalid; wd_s = axi_if.wdata;
      br_s = axi_if.bready; arv_s = axi_if.arvalid; ara_s = axi_if.araddr; rr_s = axi_if.rready;
    end
  end

  function automatic logic [31:0] exp_addr(input logic [3:0] idx, input int k);
    return 32'((int'(idx) * 4 + k) * 4);
  endfunction

  function automatic logic [31:0] exp_data(input logic [95:0] c, input int k);
    case (k)
      0:       return c[95:64];
      1:       return {16'h0, c[63:48]};
      2:       return c[47:16];
      default: return {16'h0, c[15:0]};
    endcase
  endfunction

  task automatic run_cmd(input logic [3:0] idx, input logic [95:0] cond, input int budget,
                         output int n_done, output int n_err, output int cycles);
    n_done = 0; n_err = 0; cycles = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_idx = idx; cmd_cond = cond;
    @(negedge clk);
    cmd_valid = 0;
    while (busy && cycles < budget) begin
      if (done) n_done++;
      if (err) n_err++;
      @(negedge clk);
      cycles++;
    end
    chk($sformatf("complete_idx%0d", idx), 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (err) n_err++;
    end
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic [95:0] cond;
    int          aw_d;
    int          w_d;
    int          bad;
    int          exp_done;
    int          exp_err;
    logic [2:0]  exp_code;
    int          exp_wr;
  } vec_t;

  vec_t vecs [6];
  int wf_delta [6];

  initial begin
    int nd, ne, cyc, base, hs0, br0;

    vecs[0] = '{4'd0,  {32'hC0A80102, 16'h0, 32'h0, 16'h0},             0, 0, -1, 1, 0, 3'b000, 4};
    vecs[1] = '{4'd14, 96'h0A000001_1F90_0A000002_0050,                 5, 0, -1, 1, 0, 3'b000, 4};
    vecs[2] = '{4'd15, 96'hDEADBEEF_1234_CAFEF00D_5678,                 0, 0, -1, 0, 1, 3'b001, 0};
    vecs[3] = '{4'd3,  96'h11111111_2222_33333333_4444,                 0, 0,  1, 0, 1, 3'b010, 2};
    vecs[4] = '{4'd7,  96'hAC100001_0035_AC100002_D431,                 1, 3, -1, 1, 0, 3'b000, 4};
    vecs[5] = '{4'd13, 96'hFFFFFFFF_FFFF_00000000_0001,                 2, 2, -1, 1, 0, 3'b000, 4};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_awvalid", 32'(axi_if.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi_if.wvalid), 32'd0);
    chk("rst_bready", 32'(axi_if.bready), 32'd0);
    chk("rst_arvalid", 32'(axi_if.arvalid), 32'd0);
    chk("rst_rready", 32'(axi_if.rready), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    rstn = 0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_wstrb", 32'(axi_if.wstrb), 32'hF);
    chk("idle_awprot", 32'(axi_if.awprot), 32'd0);

    for (int i = 0; i < 6; i++) begin
      aw_delay = vecs[i].aw_d; w_delay = vecs[i].w_d; bad_word = vecs[i].bad;
      base = log_n; hs0 = hs_cnt; wf_delta[i] = w_first_cnt;
      run_cmd(vecs[i].idx, vecs[i].cond, 300, nd, ne, cyc);
      wf_delta[i] = w_first_cnt - wf_delta[i];
      chk($sformatf("v%0d_done", i), 32'(nd), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(ne), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].exp_code));
      chk($sformatf("v%0d_nwr", i), 32'(log_n - base), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_hs", i), 32'(hs_cnt - hs0), 32'(2 * vecs[i].exp_wr));
      for (int k = 0; k < vecs[i].exp_wr; k++) begin
        chk($sformatf("v%0d_addr%0d", i, k), log_addr[base + k], exp_addr(vecs[i].idx, k));
        chk($sformatf("v%0d_data%0d", i, k), log_data[base + k], exp_data(vecs[i].cond, k));
      end
    end
    bad_word = -1;

    chk("v0_word0_literal", log_data[0], 32'hC0A80102);
    chk("v1_first_addr", log_addr[4], 32'h000000E0);
    chk("v1_last_addr", log_addr[7], 32'h000000EC);
    chk("v1_wvalid_drops_first", 32'(wf_delta[1] > 0), 32'd1);

    // out-of-range slot: err pulse, then cmd_ready straight after it
    aw_delay = 0; w_delay = 0;
    run_cmd(4'd15, 96'h1, 50, nd, ne, cyc);
    chk("idx15_cycles", 32'(cyc), 32'd2);
    chk("idx15_err", 32'(ne), 32'd1);
    chk("idx15_code", 32'(err_code), 32'b001);

    // cmd_valid held during busy must not start a second command
    base = log_n;
    @(negedge clk);
    cmd_valid = 1; cmd_idx = 4'd4; cmd_cond = 96'hABCDEF01_2345_6789ABCD_EF01;
    @(negedge clk);
    cmd_idx = 4'd9; cmd_cond = 96'h0;
    repeat (5) @(negedge clk);
    cmd_valid = 0;
    cyc = 0; nd = 0;
    while (busy && cyc < 200) begin
      if (done) nd++;
      @(negedge clk); cyc++;
    end
    repeat (4) @(negedge clk);
    chk("busy_ignore_nwr", 32'(log_n - base), 32'd4);
    chk("busy_ignore_done", 32'(nd), 32'd1);
    chk("busy_ignore_addr3", log_addr[base + 3], 32'h0000004C);

    // missing write response -> watchdog
    b_hold = 1;
    base = log_n; br0 = bready_cnt;
    run_cmd(4'd2, 96'h01020304_0506_0708090A_0B0C, 300, nd, ne, cyc);
    chk("tmo_err", 32'(ne), 32'd1);
    chk("tmo_done", 32'(nd), 32'd0);
    chk("tmo_code", 32'(err_code), 32'b011);
    chk("tmo_bready_cycles", 32'(bready_cnt - br0), 32'(TMO));
    chk("tmo_nwr", 32'(log_n - base), 32'd1);

    // reset in the middle of a stalled write
    aw_delay = 10;
    @(negedge clk);
    cmd_valid = 1; cmd_idx = 4'd5; cmd_cond = 96'h55555555_6666_77777777_8888;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #1 rstn = 1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_awvalid", 32'(axi_if.awvalid), 32'd0);
    chk("midrst_wvalid", 32'(axi_if.wvalid), 32'd0);
    chk("midrst_awaddr", 32'(axi_if.awaddr), 32'd0);
    chk("midrst_wdata", axi_if.wdata, 32'd0);
    chk("midrst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 0; b_hold = 0; aw_delay = 0;
    nd = 0; ne = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
      if (err) ne++;
    end
    chk("postrst_no_pulse", 32'(nd + ne), 32'd0);
    base = log_n;
    run_cmd(4'd1, 96'h0A0B0C0D_0E0F_10111213_1415, 300, nd, ne, cyc);
    chk("postrst_done", 32'(nd), 32'd1);
    chk("postrst_err", 32'(ne), 32'd0);
    chk("postrst_nwr", 32'(log_n - base), 32'd4);
    chk("postrst_addr0", log_addr[base], 32'h00000010);
    chk("postrst_data1", log_data[base + 1], 32'h00000E0F);

`ifdef FLOW_COND_LOADER_VERIFY_EN
    r_bad_word = 2;
    run_cmd(4'd6, 96'h12345678_9ABC_DEF01234_5678, 300, nd, ne, cyc);
    chk("vfy_bad_err", 32'(ne), 32'd1);
    chk("vfy_bad_code", 32'(err_code), 32'b100);
    r_bad_word = -1;
    run_cmd(4'd6, 96'h12345678_9ABC_DEF01234_5678, 300, nd, ne, cyc);
    chk("vfy_ok_done", 32'(nd), 32'd1);
    chk("vfy_ok_code", 32'(err_code), 32'b000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/flow_cond_loader.md
FLOW_COND_LOADER -- requirements
Module: flow_cond_loader

Interface
REQ-001 FLOW_NUM, default 16, flow IDs; loadable condition slots are 0..FLOW_NUM-2.
REQ-002 ADDR_WIDTH, default 8, AXI4-Lite byte-address width.
REQ-003 TIMEOUT_CYCLES, default 1024, maximum wait for any single AXI response.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid/cmd_ready  input/output  1/1  load-command handshake.
REQ-007 cmd_idx  input  4  condition slot to load.
REQ-008 cmd_cond  input  96  {src_ip[95:64], src_port[63:48], dst_ip[47:16], dst_port[15:0]}.
REQ-009 busy  output  1  command in progress.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 err  output  1  one-cycle pulse on failed completion.
REQ-012 err_code  output  3  cause, held until next command accepted.
REQ-013 m_axi_aw{addr[ADDR_WIDTH],prot[3],valid,ready}, w{data[32],strb[4],valid,ready}, b{resp[2],valid,ready}, ar{addr,prot,valid,ready}, r{data[32],resp[2],valid,ready}  AXI4-Lite master.

Function
REQ-014 cmd_ready SHALL be high only in IDLE; cmd_idx/cmd_cond SHALL be registered on handshake.
REQ-015 States: IDLE, CHECK, WR, WAIT_B, NEXT, RD_A, RD_R, FINISH; busy high in every state except IDLE.
REQ-016 CHECK: cmd_idx >= FLOW_NUM-1 -> err_code 3'b001, err pulse, no AXI traffic, return to IDLE.
REQ-017 Four writes, word k=0..3, address (idx*4+k)*4; data k0=cond[95:64], k1={16'h0,cond[63:48]}, k2=cond[47:16], k3={16'h0,cond[15:0]}.
REQ-018 WR: awvalid and wvalid asserted together; each deasserted independently on its own ready; leave WR when both done.
REQ-019 wstrb=4'hF, awprot=arprot=3'b000 always.
REQ-020 WAIT_B: bready=1; on bvalid, bresp!=2'b00 -> err_code 3'b010, abort remaining words, go FINISH.
REQ-021 NEXT: increment 2-bit word counter; k==3 wraps to 0 and exits write phase; minimum 3 cycles per write.
REQ-022 Watchdog counter reset on every state change; reaching TIMEOUT_CYCLES in WR/WAIT_B/RD_A/RD_R -> err_code 3'b011, all valids deasserted, go FINISH.
REQ-023 FINISH: exactly one of done/err pulses for one cycle, then IDLE; err_code 3'b000 on success.
REQ-024 cmd_valid in any state but IDLE SHALL be ignored (not accepted, not queued).
REQ-025 Returned bvalid/rvalid outside WAIT_B/RD_R SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE and zero all outputs (all valids, bready, rready, busy, done, err, err_code, addresses, data) immediately.
REQ-027 Reset mid-transaction SHALL abandon the command without completing or reporting it.

Configuration
REQ-028 Macro FLOW_COND_LOADER_VERIFY_EN: when defined, after four writes read back the same four addresses (RD_A arvalid until arready, RD_R rready until rvalid) and compare to written data.
REQ-029 With verify: rresp!=2'b00 -> err_code 3'b010; data mismatch -> err_code 3'b100; first failure aborts, go FINISH.
REQ-030 Without macro: RD_A/RD_R not built, arvalid and rready tied 0, write phase goes directly to FINISH.

Verification
REQ-031 idx=0, cond={192.168.1.2,0,0,0}, slave always ready -> writes 0x00=C0A80102, 0x04=0, 0x08=0, 0x0C=0; one done pulse.
REQ-032 idx=14, awready delayed 5 cycles, wready immediate -> addresses 0xE0..0xEC; wvalid drops first; done once.
REQ-033 idx=15 -> err pulse, err_code=001, zero AXI handshakes, cmd_ready back next cycle.
REQ-034 bresp=2'b10 on word 1 -> no words 2/3 written, err_code=010.
REQ-035 bvalid withheld -> err_code=011 after TIMEOUT_CYCLES; rstn pulse mid-write -> outputs zero, next command runs cleanly.
REQ-036 VERIFY_EN, word 2 readback corrupted -> err_code=100; clean readback -> done.
